mfm_write_sequencer: RTL and testbench
======================================

# mfm_write_sequencer

Sequences the MFM write path: accepts data bytes from the controller, builds the MFM clock+data half-cell stream, measures the spacing between flux transitions, and drives the existing MFM pulse shifter with one interval code per transition. It sits between the byte-level write FIFO and the shifter, and is the only block that loads the shifter's `pulses` value.

## Interface
Parameters:
- `MARK_BIT`, default 2: index of the clock bit forced to 0 when a byte is flagged as a mark. Default value 2 gives 0xA1 → 0x4489.

Ports:
- `clk`  in  1  system clock, same clock as the shifter.
- `reset`  in  1  synchronous, active-low reset.
- `wr_en`  in  1  write gate; high = write session active.
- `data`  in  8  byte to write, MSB first.
- `data_mark`  in  1  byte is a sync mark; suppress clock bit `MARK_BIT`.
- `data_valid`  in  1  `data`/`data_mark` valid.
- `data_ready`  out  1  byte accepted when `data_valid && data_ready`.
- `load`  out  1  one-cycle strobe to shifter.
- `pulses`  out  3  interval in half-cells; valid while `load` is high and held afterwards.
- `done`  in  1  shifter finished the current interval.
- `busy`  out  1  session in progress.
- `underrun`  out  1  sticky: data ran out while `wr_en` was high.

## Operation
- Raw word per byte, 16 half-cells: c7 d7 c6 d6 … c0 d0, scanned MSB first.
  - di = data bit i.
  - ci = ~d(i+1) & ~di; c7 uses the previous byte's d0, which is 0 at session start.
  - With `data_mark`, c`MARK_BIT` is forced to 0.
- Holding register: one byte.
  - `data_ready` = holding register empty & `wr_en` & state ≠ DRAIN.
- States:
  - IDLE: rising `wr_en` → SCAN. On entry to SCAN: `underrun` cleared, `busy` set, distance counter = 1, prev d0 = 0.
  - SCAN: consumes one raw half-cell per cycle.
    - Raw bit 1: pending interval ← distance, distance ← 1.
    - Raw bit 0: distance ← distance + 1, saturating at 7.
    - If a raw bit is 1 while pending is full, SCAN holds (no shift) until pending is free.
    - When 16 half-cells are consumed, the holding register transfers to the raw register in the same cycle.
    - If the holding register is empty at that point: go to DRAIN, and set `underrun` if `wr_en` is high.
  - DRAIN: trailing zeros are not emitted. Wait until pending is empty and the last `done` is seen, then go to IDLE with `busy` = 0.
- First interval of a session is max(distance, 2), i.e. SHORT.
- Interval values: SHORT = 2, MED = 3, LONG = 4. ID = 5 can only come from a mark on a non-mark-pattern byte; it is emitted as-is.
- Shifter handshake:
  - The shifter is free after reset, and again after `done` is sampled following a `load`.
  - `load` is asserted for one cycle when pending is full and the shifter is free. That load cycle frees pending.
- `wr_en` falling mid-byte: the raw and holding bytes finish; no new bytes are accepted.

## Timing
- Reset value of every output is 0: `load`, `pulses`, `data_ready`, `busy`, `underrun`.
- `load` comes 1 cycle after the later of two events: pending becomes full, or `done` is sampled.
- Simultaneous `done` and a raw 1 entering pending: `load` fires on the next cycle with the new value.
- Reset mid-operation: all state clears at the next edge and `load` goes low. An in-flight byte is discarded, and the next session starts with prev d0 = 0.
- Back-pressure (`done` held low): SCAN stalls and the holding register fills, then `data_ready` falls. No byte or interval is lost.

## Structure
- Shared package `mfm_pkg` holds SHORT/MED/LONG/ID, the state enum, and the `mfm_raw_encode(byte, prev_d0, mark)` function; the existing `define` values migrate into it.
- One sub-module, `mfm_interval_scan`: raw shift register, distance counter, and pending register. The FSM, holding register and handshake stay in the top level.

## Test plan
1. 0xA1 with `data_mark` in one session, `wr_en` dropped after accept → `pulses` sequence 2,4,3,4,3; `underrun` = 0; `busy` falls.
2. 0xA1 without mark → `pulses` sequence 2,4,3,2,2,3.
3. Bytes 0x00, 0x00 back to back → sixteen loads, all `pulses` = 2, with no gap at the byte boundary.
4. `done` held low for 20 cycles mid-byte → at most one outstanding load; `data_ready` low once holding is full; the sequence after release is identical to an unstalled run.
5. `wr_en` held high, a single byte 0xFF supplied → intervals 2,2,… then `underrun` = 1; `busy` falls after the final `done`.
6. `reset` low mid-byte for 1 cycle → all outputs 0 next cycle; a new session with 0x00 starts with first `pulses` = 2.

Source files
------------

// File: rtl/mfm_pkg.sv
// Shared MFM write-path definitions: interval codes, sequencer states and the
// byte-to-raw-half-cell encoder.
package mfm_pkg;

  localparam logic [2:0] SHORT = 3'd2;
  localparam logic [2:0] MED   = 3'd3;
  localparam logic [2:0] LONG  = 3'd4;
  localparam logic [2:0] ID    = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2
  } mfm_state_e;

  // Raw word is c7 d7 c6 d6 ... c0 d0 (c_i at bit 2i+1); mark_mask kills clock bits.
  function automatic logic [15:0] mfm_raw_encode(input logic [7:0] data_byte,
                                                 input logic       prev_d0,
                                                 input logic [7:0] mark_mask);
    logic [15:0] word;
    logic        prev;
    word = '0;
    prev = prev_d0;
    for (int i = 7; i >= 0; i--) begin
      word[2*i+1] = ~prev & ~data_byte[i] & ~mark_mask[i];
      word[2*i]   = data_byte[i];
      prev        = data_byte[i];
    end
    return word;
  endfunction

endpackage

// File: rtl/mfm_interval_scan.sv
// Walks the raw half-cell word MSB first, measures the spacing between ones
// and parks each finished interval in a one-entry pending register.
module mfm_interval_scan
  import mfm_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        en_i,
  input  logic        raw_load_i,
  input  logic [15:0] raw_i,
  input  logic        shift_load_i,
  output logic        raw_vld_o,
  output logic        word_end_o,
  output logic        pend_vld_o,
  output logic [2:0]  pend_o
);

  logic [15:0] raw_q;
  logic [4:0]  left_q;
  logic [2:0]  dist_q;
  logic        first_q;
  logic [2:0]  pend_q;
  logic        pend_vld_q;

  logic        cur_bit;
  logic        has_bit;
  logic        step;
  logic        take;
  logic [2:0]  dist_inc;
  logic [2:0]  first_val;

  assign cur_bit   = raw_q[15];
  assign has_bit   = (left_q != 5'd0);
  // A one may only advance when pending is empty or being loaded this cycle.
  assign step      = en_i && has_bit && (!cur_bit || !pend_vld_q || shift_load_i);
  assign take      = step && cur_bit;
  assign dist_inc  = (dist_q == 3'd7) ? 3'd7 : dist_q + 3'd1;
  assign first_val = (dist_q < SHORT) ? SHORT : dist_q;

  assign raw_vld_o  = has_bit;
  assign word_end_o = step && (left_q == 5'd1);
  assign pend_vld_o = pend_vld_q;
  assign pend_o     = pend_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      raw_q      <= '0;
      left_q     <= '0;
      dist_q     <= 3'd1;
      first_q    <= 1'b1;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
    end else if (clear_i) begin
      left_q     <= '0;
      dist_q     <= 3'd1;
      first_q    <= 1'b1;
      pend_vld_q <= 1'b0;
    end else begin
      if (raw_load_i) begin
        raw_q  <= raw_i;
        left_q <= 5'd16;
      end else if (step) begin
        raw_q  <= {raw_q[14:0], 1'b0};
        left_q <= left_q - 5'd1;
      end
      if (step) begin
        dist_q <= cur_bit ? 3'd1 : dist_inc;
      end
      if (take) begin
        pend_q     <= first_q ? first_val : dist_q;
        pend_vld_q <= 1'b1;
        first_q    <= 1'b0;
      end else if (shift_load_i) begin
        pend_vld_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mfm_write_sequencer.sv
// MFM write sequencer: byte intake with a one-byte holding register, session
// FSM and the load/done handshake towards the pulse shifter.
module mfm_write_sequencer
  import mfm_pkg::*;
#(
  parameter int unsigned MARK_BIT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] data,
  input  logic       data_mark,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       load,
  output logic [2:0] pulses,
  input  logic       done,
  output logic       busy,
  output logic       underrun,
  output logic [1:0] state_dbg
);

  localparam logic [7:0] MARK_MASK = 8'(1 << MARK_BIT);

  mfm_state_e  state_q, state_d;
  logic        wr_en_q;
  logic        hold_vld_q;
  logic [7:0]  hold_data_q;
  logic        hold_mark_q;
  logic        cur_d0_q;
  logic        underrun_q;
  logic        free_q;
  logic [2:0]  last_q;

  logic        raw_vld;
  logic        word_end;
  logic        pend_vld;
  logic [2:0]  pend;
  logic        start;
  logic        in_scan;
  logic        need_word;
  logic        transfer;
  logic        accept;
  logic        load_int;
  logic [15:0] raw_word;

  // Handshakes: a byte moves on data_valid && data_ready; an interval moves on
  // load, after which the shifter is busy until done is sampled high.
  assign start     = (state_q == ST_IDLE) && wr_en && !wr_en_q;
  assign in_scan   = (state_q == ST_SCAN);
  assign need_word = in_scan && (word_end || !raw_vld);
  assign transfer  = need_word && hold_vld_q;
  assign accept    = data_valid && data_ready;
  assign load_int  = pend_vld && free_q;
  assign raw_word  = mfm_raw_encode(hold_data_q, cur_d0_q, hold_mark_q ? MARK_MASK : 8'h00);

  mfm_interval_scan u_scan (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (start),
    .en_i         (in_scan),
    .raw_load_i   (transfer),
    .raw_i        (raw_word),
    .shift_load_i (load_int),
    .raw_vld_o    (raw_vld),
    .word_end_o   (word_end),
    .pend_vld_o   (pend_vld),
    .pend_o       (pend)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_SCAN;
      // Out of bytes at a word boundary, or the gate closed before any byte came.
      ST_SCAN:  if (need_word && !hold_vld_q && (word_end || !wr_en)) state_d = ST_DRAIN;
      ST_DRAIN: if (!pend_vld && free_q) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q != ST_IDLE);
    data_ready = !hold_vld_q && wr_en && (state_q != ST_DRAIN);
    load       = load_int;
    pulses     = load_int ? pend : last_q;
    underrun   = underrun_q;
    state_dbg  = state_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_en_q     <= 1'b0;
      hold_vld_q  <= 1'b0;
      hold_data_q <= '0;
      hold_mark_q <= 1'b0;
      cur_d0_q    <= 1'b0;
      underrun_q  <= 1'b0;
      free_q      <= 1'b1;
      last_q      <= '0;
    end else begin
      wr_en_q <= wr_en;
      if (accept) begin
        hold_vld_q  <= 1'b1;
        hold_data_q <= data;
        hold_mark_q <= data_mark;
      end else if (transfer) begin
        hold_vld_q <= 1'b0;
      end
      if (start) begin
        cur_d0_q <= 1'b0;
      end else if (transfer) begin
        cur_d0_q <= hold_data_q[0];
      end
      if (start) begin
        underrun_q <= 1'b0;
      end else if (in_scan && word_end && !hold_vld_q && wr_en) begin
        underrun_q <= 1'b1;
      end
      if (load_int) begin
        free_q <= 1'b0;
        last_q <= pend;
      end else if (done) begin
        free_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mfm_write_sequencer.sv
// Directed bench for mfm_write_sequencer: a shifter model answers load with done,
// and every load is compared against intervals derived from the byte stream.
module tb_mfm_write_sequencer;
  import mfm_pkg::*;

  localparam int MARK_IDX = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] data = 8'h00;
  logic       data_mark = 1'b0;
  logic       data_valid = 1'b0;
  logic       done = 1'b0;
  logic       data_ready;
  logic       load;
  logic [2:0] pulses;
  logic       busy;
  logic       underrun;
  logic [1:0] state_dbg;

  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;

  logic [2:0] exp_q[$];
  logic [2:0] model_q[$];
  logic [2:0] lit_q[$];
  logic [7:0] sess_bytes[$];
  logic       sess_marks[$];
  int         load_cyc_q[$];
  int         load_count = 0;
  int         sess_loads = 0;
  logic [2:0] first_p = 3'd0;
  logic [2:0] last_p = 3'd0;
  logic [2:0] cmp_e;

  int         done_delay = 1;
  logic       hold_done = 1'b0;
  logic       sh_busy = 1'b0;
  int         sh_cnt = 0;
  int         snap = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mfm_write_sequencer #(.MARK_BIT(MARK_IDX)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .data       (data),
    .data_mark  (data_mark),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .load       (load),
    .pulses     (pulses),
    .done       (done),
    .busy       (busy),
    .underrun   (underrun),
    .state_dbg  (state_dbg)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- shifter model ----------------
  always @(negedge clk) begin
    done = 1'b0;
    if (!reset) begin
      sh_busy = 1'b0;
    end else begin
      if (sh_busy) begin
        if (sh_cnt > 1) sh_cnt--;
        else if (!hold_done) begin
          done    = 1'b1;
          sh_busy = 1'b0;
        end
      end
      if (load) begin
        check("load_while_shifter_busy", sh_busy, 0);
        sh_busy = 1'b1;
        sh_cnt  = done_delay;
      end
    end
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      last_p = 3'd0;
    end else if (load) begin
      load_count++;
      sess_loads++;
      load_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL load_unexpected: got pulses=%0d expected no load", pulses);
      end else begin
        cmp_e = exp_q.pop_front();
        check("pulses", pulses, cmp_e);
        if (sess_loads == 1) first_p = pulses;
        last_p = cmp_e;
      end
    end else begin
      check("pulses_held", pulses, last_p);
    end
  end

  // Interval model: expand bytes to the half-cell stream, then intervals are
  // the index gaps between ones (first one measured from index -1).
  function automatic void build_model();
    logic bits[$];
    logic prev, d, c;
    int   last, gap;
    bit   first;
    model_q.delete();
    prev = 1'b0;
    foreach (sess_bytes[k]) begin
      for (int i = 7; i >= 0; i--) begin
        d = sess_bytes[k][i];
        c = !prev && !d && !(sess_marks[k] && i == MARK_IDX);
        bits.push_back(c);
        bits.push_back(d);
        prev = d;
      end
    end
    last  = -1;
    first = 1'b1;
    foreach (bits[p]) begin
      if (bits[p]) begin
        gap = p - last;
        if (gap > 7) gap = 7;
        if (first && gap < 2) gap = 2;
        model_q.push_back(3'(gap));
        first = 1'b0;
        last  = p;
      end
    end
  endfunction

  task automatic pin_model(input string name);
    check({name, "_len"}, model_q.size(), lit_q.size());
    foreach (lit_q[i]) begin
      if (i < model_q.size()) check(name, int'(model_q[i]), int'(lit_q[i]));
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send_byte(input logic [7:0] b, input logic m);
    int n;
    n          = 0;
    data       = b;
    data_mark  = m;
    data_valid = 1'b1;
    @(negedge clk);
    while (!data_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1 data_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check("busy_fall_timeout", busy, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_session(input bit keep_wr_en);
    build_model();
    foreach (model_q[i]) exp_q.push_back(model_q[i]);
    sess_loads = 0;
    load_cyc_q.delete();
    wr_en = 1'b1;
    foreach (sess_bytes[k]) send_byte(sess_bytes[k], sess_marks[k]);
    check("busy_active", busy, 1);
    if (!keep_wr_en) wr_en = 1'b0;
    wait_idle();
    check("intervals_outstanding", exp_q.size(), 0);
    check("session_loads", sess_loads, model_q.size());
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_load", load, 0);
    check("rst_pulses", pulses, 0);
    check("rst_data_ready", data_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_underrun", underrun, 0);
    @(posedge clk);
    #1 reset = 1'b1;

    // 0xA1 as a sync mark, gate dropped after accept
    sess_bytes = '{8'hA1};
    sess_marks = '{1'b1};
    build_model();
    lit_q = '{SHORT, LONG, MED, LONG, MED};
    pin_model("pin_a1_mark");
    done_delay = 1;
    run_session(1'b0);
    check("a1_mark_underrun", underrun, 0);
    check("a1_mark_busy", busy, 0);

    // 0xA1 as plain data, slower shifter
    sess_marks = '{1'b0};
    build_model();
    lit_q = '{SHORT, LONG, MED, SHORT, SHORT, MED};
    pin_model("pin_a1_plain");
    done_delay = 3;
    run_session(1'b0);

    // two zero bytes back to back: loads every other cycle across the boundary
    sess_bytes = '{8'h00, 8'h00};
    sess_marks = '{1'b0, 1'b0};
    build_model();
    lit_q.delete();
    repeat (16) lit_q.push_back(SHORT);
    pin_model("pin_zero_pair");
    done_delay = 1;
    run_session(1'b0);
    check("zero_pair_loads", load_cyc_q.size(), 16);
    for (int i = 1; i < load_cyc_q.size(); i++)
      check("zero_pair_spacing", load_cyc_q[i] - load_cyc_q[i-1], 2);

    // back-pressure: done withheld for 20 cycles from session start
    sess_bytes = '{8'h00, 8'h00, 8'h00};
    sess_marks = '{1'b0, 1'b0, 1'b0};
    hold_done  = 1'b1;
    fork
      run_session(1'b0);
      begin
        repeat (8) @(negedge clk);
        snap = load_count;
        repeat (12) @(negedge clk);
        check("stall_no_new_load", load_count - snap, 0);
        check("stall_single_load", sess_loads, 1);
        check("stall_ready_low", data_ready, 0);
        hold_done = 1'b0;
      end
    join

    // single 0xFF with the gate held high runs dry
    sess_bytes = '{8'hFF};
    sess_marks = '{1'b0};
    build_model();
    lit_q.delete();
    repeat (8) lit_q.push_back(SHORT);
    pin_model("pin_ff");
    run_session(1'b1);
    check("ff_underrun", underrun, 1);
    check("ff_busy", busy, 0);
    wr_en = 1'b0;
    @(posedge clk);
    #1;

    // mark on a non-mark byte yields the ID interval; random shifter latency
    sess_bytes = '{8'h10};
    sess_marks = '{1'b1};
    build_model();
    lit_q = '{SHORT, SHORT, SHORT, MED, ID, SHORT};
    pin_model("pin_id");
    done_delay = $urandom_range(1, 4);
    run_session(1'b0);
    check("id_underrun", underrun, 0);
    done_delay = 1;

    // reset for one cycle in the middle of a byte
    sess_bytes = '{8'h00, 8'h00};
    sess_marks = '{1'b0, 1'b0};
    build_model();
    foreach (model_q[i]) exp_q.push_back(model_q[i]);
    wr_en = 1'b1;
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b0;
    wr_en = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("mid_rst_load", load, 0);
    check("mid_rst_pulses", pulses, 0);
    check("mid_rst_data_ready", data_ready, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_underrun", underrun, 0);
    @(posedge clk);
    #1;
    sess_bytes = '{8'h00};
    sess_marks = '{1'b0};
    run_session(1'b0);
    check("post_rst_first_pulses", first_p, SHORT);

    repeat (4) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
